// File: rtl/fifo_cmd_reader_pkg.sv
// fifo_cmd_reader_pkg: word-layout defaults and FSM encoding shared by the FIFO command reader.
package fifo_cmd_reader_pkg;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_WDATA_W    = 32;
  localparam int DEF_DATA_WIDTH = 1 + DEF_ADDR_W + DEF_WDATA_W;
  localparam int DEF_TIMEOUT    = 1024;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;
endpackage

// File: rtl/fifo_cmd_reader_timeout_cnt.sv
// fifo_cmd_reader_timeout_cnt: saturating clear/enable counter flagging the last allowed cycle.
module fifo_cmd_reader_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + CW'(1);
  end
  assign expire = cnt == LAST;
endmodule

// File: rtl/fifo_cmd_reader.sv
// fifo_cmd_reader: pops command words from the FIFO and runs them one at a time on the SPI master.
module fifo_cmd_reader
  import fifo_cmd_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WDATA_W     = DEF_WDATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_write,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [WDATA_W-1:0]    cmd_wdata,
  input  logic                  spi_done,
  input  logic [WDATA_W-1:0]    spi_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WDATA_W-1:0]    rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  timeout_sticky
);
  localparam int WR_BIT = ADDR_W + WDATA_W;
  state_t state, state_nx;
  logic accept, expire, in_wait;
  assign accept  = state == ST_ISSUE && cmd_ready;
  assign in_wait = state == ST_WAIT;
  fifo_cmd_reader_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (rd_clk),
    .rst    (rd_rst),
    .clr    (accept),
    .en     (in_wait),
    .expire (expire)
  );
  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = fifo_empty ? ST_IDLE : ST_FETCH;
      ST_FETCH: state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = cmd_ready ? ST_WAIT : ST_ISSUE;
      ST_WAIT:  state_nx = spi_done ? (cmd_write ? ST_IDLE : ST_RESP) : expire ? ST_RESP : ST_WAIT;
      ST_RESP:  state_nx = rsp_ready ? ST_IDLE : ST_RESP;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_comb begin
    fifo_rd_en = state == ST_FETCH;
    cmd_valid  = state == ST_ISSUE;
    rsp_valid  = state == ST_RESP;
    busy       = state != ST_IDLE;
  end
  // spi_done takes priority over a timeout landing in the same cycle
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      cmd_write      <= 1'b0;
      cmd_addr       <= '0;
      cmd_wdata      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      timeout_sticky <= 1'b0;
    end else if (state == ST_LATCH) begin
      cmd_write <= fifo_rdata[WR_BIT];
      cmd_addr  <= fifo_rdata[WR_BIT-1:WDATA_W];
      cmd_wdata <= fifo_rdata[WDATA_W-1:0];
    end else if (in_wait && spi_done) begin
      if (!cmd_write) begin
        rsp_rdata <= spi_rdata;
        rsp_err   <= 1'b0;
      end
    end else if (in_wait && expire) begin
      rsp_rdata      <= '0;
      rsp_err        <= 1'b1;
      timeout_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_cmd_reader.sv
// tb_fifo_cmd_reader: directed scenario tasks for the FIFO command reader with a small FIFO model.
module tb_fifo_cmd_reader;
  logic        clk = 0;
  logic        rd_rst = 1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [40:0] fifo_rdata = '0;
  logic        cmd_valid;
  logic        cmd_ready = 0;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        spi_done = 0;
  logic [31:0] spi_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        timeout_sticky;
  int errors = 0, checks = 0;
  logic [40:0] mem [16];
  int push_cnt = 0, pop_cnt = 0, rd_pulses = 0, empty_pops = 0;

  fifo_cmd_reader #(.TIMEOUT_CYC(16)) dut (
    .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .spi_done(spi_done), .spi_rdata(spi_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .timeout_sticky(timeout_sticky)
  );

  always #5 clk = ~clk;
  assign fifo_empty = push_cnt == pop_cnt;

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses++;
      if (push_cnt == pop_cnt) empty_pops++;
      else begin
        fifo_rdata = mem[pop_cnt % 16];
        pop_cnt++;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [40:0] w);
    mem[push_cnt % 16] = w;
    push_cnt++;
  endtask

  task automatic test_reset;
    rd_rst = 1;
    step(2);
    rd_rst = 0;
    checks++;
    if ({fifo_rd_en, cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_valid, rsp_rdata, rsp_err, busy, timeout_sticky} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {fifo_rd_en, cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_valid, rsp_rdata, rsp_err, busy, timeout_sticky});
    end
    step();
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b rd_en=%b expected 0 0", busy, fifo_rd_en);
    end
  endtask

  task automatic test_write;
    int p0 = rd_pulses;
    push(41'h1_A5_DEADBEEF);
    step();
    checks++;
    if (fifo_rd_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_fetch: rd_en=%b busy=%b expected 1 1", fifo_rd_en, busy);
    end
    step(2);
    checks++;
    if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata} !== {1'b1, 1'b1, 8'hA5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL wr_cmd: got %h expected %h", {cmd_valid, cmd_write, cmd_addr, cmd_wdata}, {1'b1, 1'b1, 8'hA5, 32'hDEADBEEF});
    end
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept: valid=%b busy=%b expected 0 1", cmd_valid, busy);
    end
    step(4);
    spi_done = 1;
    step();
    spi_done = 0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
    checks++;
    if (rd_pulses - p0 != 1) begin
      errors++;
      $display("FAIL wr_pops: got %0d expected 1", rd_pulses - p0);
    end
  endtask

  task automatic test_read;
    int held = 0;
    push(41'h0_3C_00000000);
    step(3);
    checks++;
    if ({cmd_valid, cmd_write, cmd_addr} !== {1'b1, 1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL rd_cmd: got %h expected %h", {cmd_valid, cmd_write, cmd_addr}, {1'b1, 1'b0, 8'h3C});
    end
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    step(2);
    spi_rdata = 32'h12345678;
    spi_done = 1;
    step();
    spi_done = 0;
    spi_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid === 1'b1) held++;
      step();
    end
    checks++;
    if (held != 3 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rd_hold: held=%0d valid=%b expected 3 1", held, rsp_valid);
    end
    checks++;
    if ({rsp_err, rsp_rdata} !== {1'b0, 32'h12345678}) begin
      errors++;
      $display("FAIL rd_data: got %h expected %h", {rsp_err, rsp_rdata}, {1'b0, 32'h12345678});
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || timeout_sticky !== 1'b0) begin
      errors++;
      $display("FAIL rd_release: valid=%b busy=%b sticky=%b expected 0 0 0", rsp_valid, busy, timeout_sticky);
    end
  endtask

  task automatic test_timeout;
    push(41'h0_11_00000000);
    step(3);
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    step(15);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_early: rsp_valid=%b expected 0", rsp_valid);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, timeout_sticky} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL to_resp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata, timeout_sticky}, {1'b1, 1'b1, 32'h0, 1'b1});
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    step(2);
    checks++;
    if (timeout_sticky !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_sticky: sticky=%b busy=%b expected 1 0", timeout_sticky, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [40:0] exp_w [3] = '{41'h1_01_00000011, 41'h0_02_00000022, 41'h1_03_00000033};
    logic [40:0] prev = '0;
    logic stall = 0;
    int hs = 0, rsps = 0, cyc = 0, p0 = rd_pulses, e0 = empty_pops;
    spi_done = 1;
    spi_rdata = 32'hCAFE0000;
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) push(exp_w[i]);
    while (cyc < 100 && !(hs == 3 && !busy)) begin
      if (stall) begin
        checks++;
        if ({cmd_write, cmd_addr, cmd_wdata} !== prev) begin
          errors++;
          $display("FAIL b2b_stable: got %h expected %h", {cmd_write, cmd_addr, cmd_wdata}, prev);
        end
      end
      cmd_ready = (cyc % 3 == 2);
      if (cmd_valid && cmd_ready) begin
        checks++;
        if (hs > 2 || {cmd_write, cmd_addr, cmd_wdata} !== exp_w[hs % 3]) begin
          errors++;
          $display("FAIL b2b_order: cmd #%0d got %h expected %h", hs, {cmd_write, cmd_addr, cmd_wdata}, exp_w[hs % 3]);
        end
        hs++;
      end
      stall = cmd_valid && !cmd_ready;
      prev = {cmd_write, cmd_addr, cmd_wdata};
      if (rsp_valid) begin
        rsps++;
        checks++;
        if ({rsp_err, rsp_rdata} !== {1'b0, 32'hCAFE0000}) begin
          errors++;
          $display("FAIL b2b_rsp: got %h expected %h", {rsp_err, rsp_rdata}, {1'b0, 32'hCAFE0000});
        end
      end
      step();
      cyc++;
    end
    spi_done = 0;
    spi_rdata = '0;
    rsp_ready = 0;
    cmd_ready = 0;
    checks++;
    if (hs != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: handshakes=%0d busy=%b expected 3 0", hs, busy);
    end
    checks++;
    if (rd_pulses - p0 != 3 || empty_pops != e0) begin
      errors++;
      $display("FAIL b2b_pops: pulses=%0d empty_pops=%0d expected 3 %0d", rd_pulses - p0, empty_pops, e0);
    end
    checks++;
    if (rsps != 1) begin
      errors++;
      $display("FAIL b2b_rsps: got %0d expected 1", rsps);
    end
  endtask

  task automatic test_reset_mid;
    push(41'h0_44_00000000);
    step(3);
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    push(41'h1_55_00000055);
    step();
    checks++;
    if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rm_wait: busy=%b rd_en=%b expected 1 0", busy, fifo_rd_en);
    end
    rd_rst = 1;
    step();
    rd_rst = 0;
    checks++;
    if ({fifo_rd_en, cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_valid, rsp_rdata, rsp_err, busy, timeout_sticky} !== '0) begin
      errors++;
      $display("FAIL rm_outputs: got %h expected 0", {fifo_rd_en, cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_valid, rsp_rdata, rsp_err, busy, timeout_sticky});
    end
    spi_rdata = 32'hFFFF0000;
    spi_done = 1;
    step();
    spi_done = 0;
    spi_rdata = '0;
    checks++;
    if (rsp_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL rm_late_done: rsp_valid=%b rd_en=%b expected 0 1", rsp_valid, fifo_rd_en);
    end
    step(2);
    checks++;
    if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata} !== {1'b1, 1'b1, 8'h55, 32'h00000055}) begin
      errors++;
      $display("FAIL rm_next: got %h expected %h", {cmd_valid, cmd_write, cmd_addr, cmd_wdata}, {1'b1, 1'b1, 8'h55, 32'h00000055});
    end
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    spi_done = 1;
    step();
    spi_done = 0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_finish: busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_done_on_timeout;
    push(41'h0_66_00000000);
    step(3);
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    step(15);
    spi_rdata = 32'h0BADF00D;
    spi_done = 1;
    step();
    spi_done = 0;
    spi_rdata = '0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, timeout_sticky} !== {1'b1, 1'b0, 32'h0BADF00D, 1'b0}) begin
      errors++;
      $display("FAIL tie_resp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata, timeout_sticky}, {1'b1, 1'b0, 32'h0BADF00D, 1'b0});
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    checks++;
    if (busy !== 1'b0 || timeout_sticky !== 1'b0) begin
      errors++;
      $display("FAIL tie_end: busy=%b sticky=%b expected 0 0", busy, timeout_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_done_on_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
